// File: rtl/line_buffer_ring.sv
// Multi-line camera capture ring with an OCP-style slave read/control port.
// Optional: define LINEBUF_FRAME_FLUSH_EN so that a VSYNC rise also empties the ring.
module line_buffer_ring #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 160,
  parameter int NUM_LINES = 2,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [DATA_W-1:0] DATA,
  input  logic [2:0]        linebuf_MCmd,
  input  logic [ADDR_W-1:0] linebuf_MAddr,
  input  logic [DATA_W-1:0] linebuf_MData,
  output logic              linebuf_SCmdAccept,
  output logic [DATA_W-1:0] linebuf_SData,
  output logic [1:0]        linebuf_SResp,
  output logic              linebuf_irq
);

  localparam int COL_W  = $clog2(LINE_LEN + 1);
  localparam int PTR_W  = $clog2(NUM_LINES);
  localparam int CNT_W  = $clog2(NUM_LINES + 1);
  localparam int RAM_D  = NUM_LINES * LINE_LEN;
  localparam int RAM_AW = $clog2(RAM_D);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] line_idx_q, line_idx_d;
  logic              ovf_q, ovf_d, trunc_q, trunc_d;
  logic              href_q, vsync_q, irq_q, irq_d;
  logic [COL_W-1:0]  len_q [NUM_LINES];
  logic [COL_W-1:0]  len_d [NUM_LINES];
  logic [DATA_W-1:0] tag_q [NUM_LINES];
  logic [DATA_W-1:0] tag_d [NUM_LINES];
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pix_sel_q, pix_sel_d;

  logic [DATA_W-1:0] ram_q [RAM_D];
  logic [DATA_W-1:0] ram_rd_q;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;

  logic              href_rise, vsync_rise, flush, is_reg, pix_ok, commit, rel_fire;
  logic [ADDR_W-2:0] low_a;
  logic [DATA_W-1:0] status_w;
  logic              unused_mdata;

  assign href_rise  = HREF & ~href_q;
  assign vsync_rise = VSYNC & ~vsync_q;
  assign is_reg     = linebuf_MAddr[ADDR_W-1];
  assign low_a      = linebuf_MAddr[ADDR_W-2:0];
  assign unused_mdata = ^linebuf_MData[DATA_W-1:2];

`ifdef LINEBUF_FRAME_FLUSH_EN
  assign flush = vsync_rise;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_LINES - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    line_idx_d = line_idx_q;
    ovf_d      = ovf_q;
    trunc_d    = trunc_q;
    len_d      = len_q;
    tag_d      = tag_q;
    resp_d     = RESP_NULL;
    rdata_d    = '0;
    pix_sel_d  = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_raddr  = '0;
    commit     = 1'b0;
    rel_fire   = 1'b0;
    status_w   = '0;
    status_w[DATA_W-1]  = ovf_q;
    status_w[DATA_W-2]  = trunc_q;
    status_w[CNT_W-1:0] = count_q;
    pix_ok = (count_q != '0) && (32'(low_a) < 32'(len_q[rd_ptr_q]));

    // Bus side first so that a capture-side flag set in the same cycle wins over CLEAR.
    if (linebuf_MCmd != CMD_IDLE) begin
      resp_d = RESP_ERR;
      if (linebuf_MCmd == CMD_RD && !is_reg) begin
        if (pix_ok) begin
          resp_d    = RESP_DVA;
          pix_sel_d = 1'b1;
          ram_raddr = RAM_AW'(32'(rd_ptr_q) * LINE_LEN + 32'(low_a));
        end
      end else if (linebuf_MCmd == CMD_RD) begin
        case (32'(low_a))
          0: begin resp_d = RESP_DVA; rdata_d = status_w; end
          1: begin
            resp_d  = RESP_DVA;
            rdata_d = (count_q != '0) ? DATA_W'(len_q[rd_ptr_q]) : '0;
          end
          2: begin resp_d = RESP_DVA; rdata_d = tag_q[rd_ptr_q]; end
          default: ;
        endcase
      end else if (linebuf_MCmd == CMD_WR && is_reg) begin
        case (32'(low_a))
          3: if (count_q != '0 && !flush) begin
            resp_d   = RESP_DVA;
            rel_fire = 1'b1;
          end
          4: begin
            resp_d = RESP_DVA;
            if (linebuf_MData[1]) ovf_d   = 1'b0;
            if (linebuf_MData[0]) trunc_d = 1'b0;
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      S_IDLE: if (href_rise) begin
        if (32'(count_q) < NUM_LINES) begin
          ram_we    = 1'b1;
          ram_waddr = RAM_AW'(32'(wr_ptr_q) * LINE_LEN);
          col_d     = COL_W'(1);
          state_d   = S_CAPTURE;
        end else begin
          ovf_d   = 1'b1;
          state_d = S_DROP;
        end
      end
      S_CAPTURE: begin
        if (HREF) begin
          if (32'(col_q) < LINE_LEN) begin
            ram_we    = 1'b1;
            ram_waddr = RAM_AW'(32'(wr_ptr_q) * LINE_LEN + 32'(col_q));
            col_d     = col_q + COL_W'(1);
          end else begin
            trunc_d = 1'b1;
          end
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit           = 1'b1;
        len_d[wr_ptr_q]  = col_q;
        tag_d[wr_ptr_q]  = line_idx_q;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        line_idx_d       = line_idx_q + DATA_W'(1);
        state_d          = S_IDLE;
      end
      default: if (!HREF) begin
        line_idx_d = line_idx_q + DATA_W'(1);
        state_d    = S_IDLE;
      end
    endcase

    if (rel_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (commit && !rel_fire)      count_d = count_q + CNT_W'(1);
    else if (!commit && rel_fire) count_d = count_q - CNT_W'(1);

    if (vsync_rise) line_idx_d = '0;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      col_d    = '0;
      ram_we   = 1'b0;
      state_d  = S_IDLE;
    end

    irq_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      line_idx_q <= '0;
      ovf_q      <= 1'b0;
      trunc_q    <= 1'b0;
      // Treat HREF as already high so a line in flight at reset release is not seen as a rise.
      href_q     <= 1'b1;
      vsync_q    <= 1'b0;
      irq_q      <= 1'b0;
      resp_q     <= RESP_NULL;
      rdata_q    <= '0;
      pix_sel_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        len_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      line_idx_q <= line_idx_d;
      ovf_q      <= ovf_d;
      trunc_q    <= trunc_d;
      href_q     <= HREF;
      vsync_q    <= VSYNC;
      irq_q      <= irq_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      pix_sel_q  <= pix_sel_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= DATA;
    ram_rd_q <= ram_q[ram_raddr];
  end

  assign linebuf_SCmdAccept = (linebuf_MCmd != CMD_IDLE);
  assign linebuf_SResp      = resp_q;
  assign linebuf_SData      = pix_sel_q ? ram_rd_q : rdata_q;
  assign linebuf_irq        = irq_q;

endmodule

// File: tb/tb_line_buffer_ring.sv
// Directed bench for line_buffer_ring: register/pixel vector table plus capture corner sequences.
module tb_line_buffer_ring;

  localparam logic [2:0] RD = 3'b010;
  localparam logic [2:0] WR = 3'b001;
  localparam logic [8:0] A_STATUS = 9'h100;
  localparam logic [8:0] A_LEN    = 9'h101;
  localparam logic [8:0] A_IDX    = 9'h102;
  localparam logic [8:0] A_REL    = 9'h103;
  localparam logic [8:0] A_CLR    = 9'h104;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HREF = 1'b0;
  logic [7:0] DATA = '0;
  logic [2:0] MCmd = '0;
  logic [8:0] MAddr = '0;
  logic [7:0] MData = '0;
  logic       SCmdAccept;
  logic [7:0] SData;
  logic [1:0] SResp;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] cmd;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [1:0] resp;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[14];

  line_buffer_ring #(.DATA_W(8), .LINE_LEN(160), .NUM_LINES(2), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .linebuf_MCmd(MCmd), .linebuf_MAddr(MAddr), .linebuf_MData(MData),
    .linebuf_SCmdAccept(SCmdAccept), .linebuf_SData(SData),
    .linebuf_SResp(SResp), .linebuf_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_op(input logic [2:0] cmd, input logic [8:0] addr, input logic [7:0] wd,
                        output logic [1:0] resp, output logic [7:0] d, output logic acc);
    @(negedge clk);
    MCmd = cmd; MAddr = addr; MData = wd;
    #1 acc = SCmdAccept;
    @(negedge clk);
    resp = SResp; d = SData;
    MCmd = '0; MAddr = '0; MData = '0;
  endtask

  task automatic rd_reg(input logic [8:0] addr, input logic [7:0] exp, input string nm);
    logic [1:0] r; logic [7:0] d; logic a;
    bus_op(RD, addr, 8'h00, r, d, a);
    chk({nm, " resp"}, r, 1);
    chk({nm, " data"}, d, exp);
  endtask

  task automatic op_resp(input logic [2:0] cmd, input logic [8:0] addr, input logic [7:0] wd,
                         input logic [1:0] exp, input string nm);
    logic [1:0] r; logic [7:0] d; logic a;
    bus_op(cmd, addr, wd, r, d, a);
    chk({nm, " resp"}, r, exp);
    chk({nm, " data"}, d, 0);
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      HREF = 1'b1; DATA = base + 8'(i);
    end
    @(negedge clk);
    HREF = 1'b0; DATA = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk); VSYNC = 1'b1;
    @(negedge clk); VSYNC = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [1:0] r; logic [7:0] d; logic a;

    vecs[0]  = '{RD, A_STATUS, 8'h00, 2'b01, 8'h01};
    vecs[1]  = '{RD, A_LEN,    8'h00, 2'b01, 8'hA0};
    vecs[2]  = '{RD, A_IDX,    8'h00, 2'b01, 8'h00};
    vecs[3]  = '{RD, 9'h005,   8'h00, 2'b01, 8'h05};
    vecs[4]  = '{RD, 9'h09F,   8'h00, 2'b01, 8'h9F};
    vecs[5]  = '{RD, 9'h0A0,   8'h00, 2'b11, 8'h00};
    vecs[6]  = '{RD, 9'h105,   8'h00, 2'b11, 8'h00};
    vecs[7]  = '{WR, 9'h000,   8'h55, 2'b11, 8'h00};
    vecs[8]  = '{WR, A_STATUS, 8'hFF, 2'b11, 8'h00};
    vecs[9]  = '{3'b011, 9'h000, 8'h00, 2'b11, 8'h00};
    vecs[10] = '{WR, A_CLR,    8'h03, 2'b01, 8'h00};
    vecs[11] = '{RD, 9'h000,   8'h00, 2'b01, 8'h00};
    vecs[12] = '{RD, A_STATUS, 8'h00, 2'b01, 8'h01};
    vecs[13] = '{RD, 9'h0FF,   8'h00, 2'b11, 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset SResp", SResp, 0);
    chk("reset SData", SData, 0);
    chk("reset irq", irq, 0);
    chk("reset accept", SCmdAccept, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One full 160-pixel line, DATA = column
    send_line(160, 8'h00);
    chk("t1 irq", irq, 1);
    for (int i = 0; i < 14; i++) begin
      bus_op(vecs[i].cmd, vecs[i].addr, vecs[i].wd, r, d, a);
      chk($sformatf("vec%0d accept", i), a, 1);
      chk($sformatf("vec%0d resp", i), r, vecs[i].resp);
      chk($sformatf("vec%0d data", i), d, vecs[i].data);
    end

    // Response appears exactly one cycle after accept, then returns to NULL
    @(negedge clk); MCmd = RD; MAddr = 9'h005;
    #1 chk("lat same-cycle resp", SResp, 0);
    @(negedge clk); MCmd = '0; MAddr = '0;
    chk("lat resp", SResp, 1);
    chk("lat data", SData, 8'h05);
    @(negedge clk);
    chk("lat idle resp", SResp, 0);
    chk("lat idle data", SData, 0);

    // Drain to empty and probe the empty-ring error paths
    op_resp(WR, A_REL, 8'h00, 2'b01, "t1 release");
    @(negedge clk);
    chk("t1 irq after release", irq, 0);
    rd_reg(A_STATUS, 8'h00, "empty status");
    rd_reg(A_LEN, 8'h00, "empty len");
    op_resp(RD, 9'h000, 8'h00, 2'b11, "empty rd px");
    op_resp(WR, A_REL, 8'h00, 2'b11, "empty release");

    // Three lines into a two-slot ring: third dropped
    vsync_pulse();
    send_line(10, 8'h10);
    send_line(20, 8'h40);
    send_line(30, 8'h80);
    rd_reg(A_STATUS, 8'h82, "t2 status");
    chk("t2 irq", irq, 1);
    rd_reg(A_LEN, 8'd10, "t2 len0");
    rd_reg(A_IDX, 8'd0, "t2 idx0");
    op_resp(RD, 9'd12, 8'h00, 2'b11, "t2 px12");
    op_resp(RD, 9'd10, 8'h00, 2'b11, "t2 px10");
    rd_reg(9'd9, 8'h19, "t2 px9");
    op_resp(WR, A_REL, 8'h00, 2'b01, "t2 release");
    rd_reg(A_LEN, 8'd20, "t2 len1");
    rd_reg(A_IDX, 8'd1, "t2 idx1");
    rd_reg(9'd19, 8'h53, "t2 px19");
    rd_reg(A_STATUS, 8'h81, "t2 status2");

    // Overlong line truncated at LINE_LEN
    send_line(170, 8'h00);
    rd_reg(A_STATUS, 8'hC2, "t3 status");
    op_resp(WR, A_CLR, 8'h01, 2'b01, "t3 clear trunc");
    rd_reg(A_STATUS, 8'h82, "t3 status2");
    op_resp(WR, A_REL, 8'h00, 2'b01, "t3 release");
    rd_reg(A_LEN, 8'hA0, "t3 len");
    rd_reg(A_IDX, 8'd3, "t3 idx");
    rd_reg(9'd159, 8'h9F, "t3 px159");
    op_resp(RD, 9'd165, 8'h00, 2'b11, "t3 px165");
    op_resp(WR, A_CLR, 8'h02, 2'b01, "t3 clear ovf");
    rd_reg(A_STATUS, 8'h01, "t3 status3");

    // RELEASE in the same cycle as COMMIT
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); HREF = 1'b1; DATA = 8'h60 + 8'(i);
    end
    @(negedge clk); HREF = 1'b0; DATA = '0;
    @(negedge clk); MCmd = WR; MAddr = A_REL;
    @(negedge clk); MCmd = '0; MAddr = '0;
    chk("t5 coincident release resp", SResp, 1);
    repeat (2) @(negedge clk);
    rd_reg(A_STATUS, 8'h01, "t5 status");
    rd_reg(A_LEN, 8'd5, "t5 len");
    rd_reg(A_IDX, 8'd4, "t5 idx");
    rd_reg(9'd4, 8'h64, "t5 px4");
    send_line(7, 8'h20);
    op_resp(WR, A_REL, 8'h00, 2'b01, "t5 release a");
    rd_reg(A_LEN, 8'd7, "t5 len7");
    rd_reg(A_IDX, 8'd5, "t5 idx5");
    send_line(3, 8'h30);
    rd_reg(A_STATUS, 8'h02, "t5 full status");

    // RELEASE frees a slot for an HREF rise on the very next cycle
    @(negedge clk); MCmd = WR; MAddr = A_REL;
    @(negedge clk); MCmd = '0; MAddr = '0;
    chk("t5 release b resp", SResp, 1);
    HREF = 1'b1; DATA = 8'h70;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); DATA = 8'h70 + 8'(i);
    end
    @(negedge clk); HREF = 1'b0; DATA = '0;
    repeat (3) @(negedge clk);
    rd_reg(A_STATUS, 8'h02, "t5 reuse status");
    rd_reg(A_LEN, 8'd3, "t5 len3");
    rd_reg(A_IDX, 8'd6, "t5 idx6");
    op_resp(WR, A_REL, 8'h00, 2'b01, "t5 release c");
    rd_reg(A_LEN, 8'd4, "t5 len4");
    rd_reg(A_IDX, 8'd7, "t5 idx7");
    rd_reg(9'd3, 8'h73, "t5 px3");
    op_resp(WR, A_REL, 8'h00, 2'b01, "t5 release d");
    rd_reg(A_STATUS, 8'h00, "t5 empty");

    // VSYNC with one line held
    send_line(8, 8'h80);
    vsync_pulse();
`ifdef LINEBUF_FRAME_FLUSH_EN
    rd_reg(A_STATUS, 8'h00, "t6 flushed status");
    chk("t6 flushed irq", irq, 0);
`else
    rd_reg(A_STATUS, 8'h01, "t6 kept status");
    chk("t6 kept irq", irq, 1);
    rd_reg(A_LEN, 8'd8, "t6 kept len");
    rd_reg(A_IDX, 8'd8, "t6 kept idx");
`endif
    send_line(2, 8'h90);
`ifndef LINEBUF_FRAME_FLUSH_EN
    op_resp(WR, A_REL, 8'h00, 2'b01, "t6 release");
`endif
    rd_reg(A_STATUS, 8'h01, "t6 status");
    rd_reg(A_LEN, 8'd2, "t6 len");
    rd_reg(A_IDX, 8'd0, "t6 new idx");

    // Reset asserted mid-line; the partial line after release must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); HREF = 1'b1; DATA = 8'hA0 + 8'(i);
    end
    #2 rst_n = 1'b0;
    #1 chk("midrst irq", irq, 0);
    chk("midrst resp", SResp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    HREF = 1'b0;
    repeat (3) @(negedge clk);
    rd_reg(A_STATUS, 8'h00, "midrst status");
    send_line(4, 8'hB0);
    rd_reg(A_STATUS, 8'h01, "postrst status");
    rd_reg(A_LEN, 8'd4, "postrst len");
    rd_reg(A_IDX, 8'd0, "postrst idx");
    rd_reg(9'd3, 8'hB3, "postrst px3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
